// File: rtl/deconv_col_scheduler.sv
// Column-wise deconvolution sequencer.
// Walks kernel column -> input column -> channel, issuing one-cycle load strobes
// to the core and waiting out each compute on the core's ready handshake.
// All strobes and ids are registered, so they are glitch-free and change only on clock edges.
// On the last ADV of a pass the ids hold at their final values instead of wrapping.
module deconv_col_scheduler #(
    parameter int REG_WIDTH    = 32,
    parameter int FEATURE_SIZE = 8,
    parameter int WEIGHT_SIZE  = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [REG_WIDTH-1:0] i_num_chnl,
    input  logic                 i_ip_valid,
    input  logic                 i_w_valid,
    input  logic                 i_core_ready,
    output logic                 o_enable_loadip,
    output logic                 o_enable_loadw,
    output logic [REG_WIDTH-1:0] o_kernel_col_id,
    output logic [REG_WIDTH-1:0] o_input_col_id,
    output logic [REG_WIDTH-1:0] o_chnl_id,
    output logic                 o_fifo_loop,
    output logic                 o_new_chnl,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [REG_WIDTH-1:0] ONE       = REG_WIDTH'(1);
    localparam logic [REG_WIDTH-1:0] KCOL_LAST = REG_WIDTH'(WEIGHT_SIZE - 1);
    localparam logic [REG_WIDTH-1:0] ICOL_LAST = REG_WIDTH'(FEATURE_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        LD_IP,
        LD_W,
        WAIT_BSY,
        WAIT_RDY,
        ADV,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [REG_WIDTH-1:0] kcol;
    logic [REG_WIDTH-1:0] icol;
    logic [REG_WIDTH-1:0] chnl;
    logic [REG_WIDTH-1:0] num_chnl;

    logic start_ok;
    logic kcol_last;
    logic icol_last;
    logic chnl_last;

    logic loadip_d;
    logic loadw_d;
    logic fifo_loop_d;
    logic new_chnl_d;
    logic done_d;
    logic busy_d;

    // A start is only honoured in IDLE, and not in the cycle o_done is still showing
    assign start_ok  = (state == IDLE) && i_start && !o_done;
    assign kcol_last = (kcol == KCOL_LAST);
    assign icol_last = (icol == ICOL_LAST);
    assign chnl_last = (chnl == (num_chnl - ONE));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: walk load input -> load weight -> core busy -> core ready -> advance
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_ok)      state_nxt = LD_IP;
            LD_IP:    if (i_ip_valid)    state_nxt = LD_W;
            LD_W:     if (i_w_valid)     state_nxt = WAIT_BSY;
            WAIT_BSY: if (!i_core_ready) state_nxt = WAIT_RDY;
            WAIT_RDY: if (i_core_ready)  state_nxt = ADV;
            ADV: begin
                if (!kcol_last) begin
                    state_nxt = LD_W;
                end else if (!icol_last || !chnl_last) begin
                    state_nxt = LD_IP;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output decode: next values of the registered strobes and busy flag
    always_comb begin
        loadip_d    = (state == LD_IP) && i_ip_valid;
        loadw_d     = (state == LD_W) && i_w_valid;
        fifo_loop_d = (state == ADV) && kcol_last;
        new_chnl_d  = (state == ADV) && kcol_last && icol_last;
        done_d      = (state == DONE);
        busy_d      = o_busy;
        if (start_ok) begin
            busy_d = 1'b1;
        end else if (state == DONE) begin
            busy_d = 1'b0;
        end
    end

    // Output registers, cleared immediately on reset so an aborted pass emits nothing more
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_enable_loadip <= 1'b0;
            o_enable_loadw  <= 1'b0;
            o_fifo_loop     <= 1'b0;
            o_new_chnl      <= 1'b0;
            o_done          <= 1'b0;
            o_busy          <= 1'b0;
        end else begin
            o_enable_loadip <= loadip_d;
            o_enable_loadw  <= loadw_d;
            o_fifo_loop     <= fifo_loop_d;
            o_new_chnl      <= new_chnl_d;
            o_done          <= done_d;
            o_busy          <= busy_d;
        end
    end

    // Position counters: cleared on start, stepped only in ADV, held on the final step
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            kcol     <= '0;
            icol     <= '0;
            chnl     <= '0;
            num_chnl <= '0;
        end else if (start_ok) begin
            kcol     <= '0;
            icol     <= '0;
            chnl     <= '0;
            num_chnl <= (i_num_chnl == '0) ? ONE : i_num_chnl;
        end else if (state == ADV) begin
            if (!kcol_last) begin
                kcol <= kcol + ONE;
            end else if (!icol_last) begin
                kcol <= '0;
                icol <= icol + ONE;
            end else if (!chnl_last) begin
                kcol <= '0;
                icol <= '0;
                chnl <= chnl + ONE;
            end
        end
    end

    assign o_kernel_col_id = kcol;
    assign o_input_col_id  = icol;
    assign o_chnl_id       = chnl;

endmodule
